axi_lite_read_seq_master: RTL and testbench

Parametrised AXI4-Lite read master. It issues a programmable sequence of single-beat reads: `count` reads starting at `base_addr`, with the address advancing by `stride` after each read. Each returned word is streamed to a local consumer together with its sequence index. Response errors and timeouts are captured in status outputs. The block replaces fixed-address, single-read masters on the m_ AXI read channel and drives the same slave_file-style slaves.

---
 rtl/axi_lite_read_seq_master_if.sv | 26 ++
 rtl/axi_lite_read_seq_master.sv | 170 +++++++++++++++++
 tb/tb_axi_lite_read_seq_master.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_read_seq_master_if.sv
// AXI4-Lite read-channel bundle (AR + R) between the sequencing master and its slave.
interface axi_lite_read_seq_master_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] m_araddr;
   logic [2:0]        m_arprot;
   logic              m_arvalid;
   logic              m_arready;
   logic [DATA_W-1:0] m_rdata;
   logic [1:0]        m_rresp;
   logic              m_rvalid;
   logic              m_rready;

   // valid/ready: a beat transfers on a rising clock edge where both are high;
   // once valid is raised its payload is held stable and valid is never withdrawn before ready.
   modport master (
      output m_araddr, m_arprot, m_arvalid, m_rready,
      input  m_arready, m_rdata, m_rresp, m_rvalid
   );

   modport slave (
      input  m_araddr, m_arprot, m_arvalid, m_rready,
      output m_arready, m_rdata, m_rresp, m_rvalid
   );
endinterface

// File: rtl/axi_lite_read_seq_master.sv
// AXI4-Lite read master that issues `count` single-beat reads from base_addr stepping by stride,
// streaming each word with its index and tracking response errors and phase timeouts.
module axi_lite_read_seq_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int CNT_WIDTH          = 4,
   parameter int TIMEOUT_CYCLES     = 16,
   parameter int STOP_ON_ERR        = 1
) (
   input  logic                          m_aclk,
   input  logic                          m_areset,
   input  logic                          start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] stride,
   input  logic [CNT_WIDTH-1:0]          count,
   output logic                          busy,
   output logic                          done,
   output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data_out,
   output logic                          rd_data_valid,
   output logic [CNT_WIDTH-1:0]          rd_index,
   output logic                          err,
   output logic [CNT_WIDTH-1:0]          err_index,
   output logic [1:0]                    err_resp,
   output logic                          timeout,
   output logic [1:0]                    dbg_state,
   axi_lite_read_seq_master_if.master    m_axi
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // One spare count above the limit so the saturated value can never alias the trigger value.
   localparam int            TW     = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);

   logic [1:0]                    state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [CNT_WIDTH-1:0]          count_q, count_d;
   logic [CNT_WIDTH-1:0]          idx_q, idx_d;
   logic [C_M_AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                          rd_valid_q, rd_valid_d;
   logic [CNT_WIDTH-1:0]          rd_index_q, rd_index_d;
   logic                          err_q, err_d;
   logic [CNT_WIDTH-1:0]          err_index_q, err_index_d;
   logic [1:0]                    err_resp_q, err_resp_d;
   logic                          timeout_q, timeout_d;
   logic [TW-1:0]                 phase_cnt_q, phase_cnt_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      count_d     = count_q;
      idx_d       = idx_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      rd_index_d  = rd_index_q;
      err_d       = err_q;
      err_index_d = err_index_q;
      err_resp_d  = err_resp_q;
      timeout_d   = timeout_q;
      phase_cnt_d = phase_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d       = 1'b0;
               err_index_d = '0;
               err_resp_d  = 2'b00;
               timeout_d   = 1'b0;
               count_d     = count;
               if (count != '0) begin
                  addr_d      = base_addr;
                  stride_d    = stride;
                  idx_d       = '0;
                  phase_cnt_d = '0;
                  state_d     = S_ADDR;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ADDR: begin
            if (m_axi.m_arready) begin
               phase_cnt_d = '0;
               state_d     = S_DATA;
            end
         end
         S_DATA: begin
            if (m_axi.m_rvalid) begin
               rd_data_d  = m_axi.m_rdata;
               rd_valid_d = 1'b1;
               rd_index_d = idx_q;
               if ((m_axi.m_rresp != 2'b00) && !err_q) begin
                  err_d       = 1'b1;
                  err_index_d = idx_q;
                  err_resp_d  = m_axi.m_rresp;
               end
               if ((idx_q == (count_q - CNT_WIDTH'(1))) ||
                   ((STOP_ON_ERR != 0) && (m_axi.m_rresp != 2'b00))) begin
                  state_d = S_DONE;
               end else begin
                  idx_d       = idx_q + CNT_WIDTH'(1);
                  addr_d      = addr_q + stride_q;
                  phase_cnt_d = '0;
                  state_d     = S_ADDR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timeout only flags a slow phase; the handshake itself is always carried to completion.
      if ((TIMEOUT_CYCLES != 0) && ((state_q == S_ADDR) || (state_q == S_DATA)) &&
          (state_d == state_q)) begin
         if (phase_cnt_q != TO_VAL) phase_cnt_d = phase_cnt_q + TW'(1);
         if ((phase_cnt_q + TW'(1)) == TO_VAL) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge m_aclk) begin
      if (m_areset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         stride_q    <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_index_q  <= '0;
         err_q       <= 1'b0;
         err_index_q <= '0;
         err_resp_q  <= 2'b00;
         timeout_q   <= 1'b0;
         phase_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_index_q  <= rd_index_d;
         err_q       <= err_d;
         err_index_q <= err_index_d;
         err_resp_q  <= err_resp_d;
         timeout_q   <= timeout_d;
         phase_cnt_q <= phase_cnt_d;
      end
   end

   assign busy          = (state_q == S_ADDR) || (state_q == S_DATA);
   assign done          = (state_q == S_DONE);
   assign rd_data_out   = rd_data_q;
   assign rd_data_valid = rd_valid_q;
   assign rd_index      = rd_index_q;
   assign err           = err_q;
   assign err_index     = err_index_q;
   assign err_resp      = err_resp_q;
   assign timeout       = timeout_q;
   assign dbg_state     = state_q;

   assign m_axi.m_araddr  = addr_q;
   assign m_axi.m_arprot  = 3'b000;
   assign m_axi.m_arvalid = (state_q == S_ADDR);
   assign m_axi.m_rready  = (state_q == S_DATA);
endmodule

// File: tb/tb_axi_lite_read_seq_master.sv
// Bench for axi_lite_read_seq_master: reactive slave model plus an address/data scoreboard,
// with a second instance built to keep reading past response errors.
module tb_axi_lite_read_seq_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, start1 = 1'b0;
   logic [3:0]  base_addr = '0, stride = '0, count = '0;

   logic        busy0, done0, rd_valid0, err0, timeout0;
   logic [31:0] rd_data0;
   logic [3:0]  rd_index0, err_index0;
   logic [1:0]  err_resp0, dbg_state0;
   logic        busy1, done1, rd_valid1, err1, timeout1;
   logic [31:0] rd_data1;
   logic [3:0]  rd_index1, err_index1;
   logic [1:0]  err_resp1, dbg_state1;

   axi_lite_read_seq_master_if #(.ADDR_W(4), .DATA_W(32)) ax0 ();
   axi_lite_read_seq_master_if #(.ADDR_W(4), .DATA_W(32)) ax1 ();

   axi_lite_read_seq_master #(.TIMEOUT_CYCLES(16), .STOP_ON_ERR(1)) u0 (
      .m_aclk(clk), .m_areset(rst), .start(start), .base_addr(base_addr), .stride(stride),
      .count(count), .busy(busy0), .done(done0), .rd_data_out(rd_data0),
      .rd_data_valid(rd_valid0), .rd_index(rd_index0), .err(err0), .err_index(err_index0),
      .err_resp(err_resp0), .timeout(timeout0), .dbg_state(dbg_state0), .m_axi(ax0)
   );

   axi_lite_read_seq_master #(.TIMEOUT_CYCLES(16), .STOP_ON_ERR(0)) u1 (
      .m_aclk(clk), .m_areset(rst), .start(start1), .base_addr(base_addr), .stride(stride),
      .count(count), .busy(busy1), .done(done1), .rd_data_out(rd_data1),
      .rd_data_valid(rd_valid1), .rd_index(rd_index1), .err(err1), .err_index(err_index1),
      .err_resp(err_resp1), .timeout(timeout1), .dbg_state(dbg_state1), .m_axi(ax1)
   );

   always #5 clk = ~clk;

   int assert_cnt = 0, fail_cnt = 0;

   // slave knobs and memory image
   logic [31:0] mem [16];
   int          ar_delay = 0;
   int          err_num = -1;
   bit          r_hold = 1'b0;

   // scoreboard for u0
   logic [3:0]  exp_addr_q [$];
   logic [35:0] exp_rd_q [$];
   int          ar_seen = 0, valid_seen = 0, done_seen = 0;
   int          valid1_seen = 0, done1_seen = 0;
   int          addr_cycles = 0, to_at = 0;
   bit          to_prev = 1'b0;

   // slave for u0, with AR stability checking
   int          ar_wait0 = 0, rd_num0 = 0;
   logic [3:0]  lat_addr0 = '0, prev_addr0 = '0;
   bit          prev_arv0 = 1'b0, prev_ardy0 = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         ax0.m_arready = 1'b0; ax0.m_rvalid = 1'b0; ax0.m_rdata = '0; ax0.m_rresp = 2'b00;
         ar_wait0 = 0; prev_arv0 = 1'b0; prev_ardy0 = 1'b0;
      end else begin
         if (prev_arv0 && !prev_ardy0) begin
            assert_cnt++;
            if (ax0.m_arvalid !== 1'b1 || ax0.m_araddr !== prev_addr0) begin
               fail_cnt++;
               $display("FAIL ar_stable: arvalid=%b araddr=%h, required arvalid=1 araddr=%h",
                        ax0.m_arvalid, ax0.m_araddr, prev_addr0);
            end
         end
         if (ax0.m_arvalid) begin
            if (ar_wait0 >= ar_delay) begin
               ax0.m_arready = 1'b1;
               lat_addr0 = ax0.m_araddr;
            end else begin
               ax0.m_arready = 1'b0;
               ar_wait0++;
            end
         end else begin
            ax0.m_arready = 1'b0;
            ar_wait0 = 0;
         end
         prev_arv0 = ax0.m_arvalid; prev_ardy0 = ax0.m_arready; prev_addr0 = ax0.m_araddr;
         if (ax0.m_rready && !r_hold) begin
            ax0.m_rvalid = 1'b1;
            ax0.m_rdata  = mem[lat_addr0];
            ax0.m_rresp  = (rd_num0 == err_num) ? 2'b10 : 2'b00;
            rd_num0++;
         end else begin
            ax0.m_rvalid = 1'b0;
         end
      end
   end

   // slave for u1
   int          ar_wait1 = 0, rd_num1 = 0;
   logic [3:0]  lat_addr1 = '0;

   always @(negedge clk) begin
      if (rst) begin
         ax1.m_arready = 1'b0; ax1.m_rvalid = 1'b0; ax1.m_rdata = '0; ax1.m_rresp = 2'b00;
         ar_wait1 = 0;
      end else begin
         if (ax1.m_arvalid) begin
            if (ar_wait1 >= ar_delay) begin
               ax1.m_arready = 1'b1;
               lat_addr1 = ax1.m_araddr;
            end else begin
               ax1.m_arready = 1'b0;
               ar_wait1++;
            end
         end else begin
            ax1.m_arready = 1'b0;
            ar_wait1 = 0;
         end
         if (ax1.m_rready && !r_hold) begin
            ax1.m_rvalid = 1'b1;
            ax1.m_rdata  = mem[lat_addr1];
            ax1.m_rresp  = (rd_num1 == err_num) ? 2'b10 : 2'b00;
            rd_num1++;
         end else begin
            ax1.m_rvalid = 1'b0;
         end
      end
   end

   // monitor: runs after the slaves have settled in the low clock phase
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (ax0.m_arvalid && ax0.m_arready) begin
            logic [3:0] ea;
            ar_seen++;
            assert_cnt++;
            if (exp_addr_q.size() == 0) begin
               fail_cnt++;
               $display("FAIL ar_unexpected: araddr=%h, required no AR", ax0.m_araddr);
            end else begin
               ea = exp_addr_q.pop_front();
               if (ax0.m_araddr !== ea) begin
                  fail_cnt++;
                  $display("FAIL araddr: got %h, required %h", ax0.m_araddr, ea);
               end
            end
         end
         if (rd_valid0) begin
            logic [35:0] er;
            valid_seen++;
            assert_cnt++;
            if (exp_rd_q.size() == 0) begin
               fail_cnt++;
               $display("FAIL rd_unexpected: idx=%0d data=%h, required no read", rd_index0, rd_data0);
            end else begin
               er = exp_rd_q.pop_front();
               if ({rd_index0, rd_data0} !== er) begin
                  fail_cnt++;
                  $display("FAIL rd_data: got idx=%0d data=%h, required idx=%0d data=%h",
                           rd_index0, rd_data0, er[35:32], er[31:0]);
               end
            end
         end
         if (done0) begin
            done_seen++;
            assert_cnt++;
            if (busy0 !== 1'b0) begin
               fail_cnt++;
               $display("FAIL busy_at_done: got %b, required 0", busy0);
            end
         end
         if (rd_valid1) valid1_seen++;
         if (done1) done1_seen++;
         addr_cycles = ax0.m_arvalid ? addr_cycles + 1 : 0;
         if (timeout0 && !to_prev) to_at = addr_cycles;
         to_prev = timeout0;
      end
   end

   task automatic run_seq(input logic [3:0] b, input logic [3:0] s, input logic [3:0] c,
                          input int n_exp, input bit use_u1, input bit poke, output int lat);
      logic [3:0] a;
      ar_seen = 0; valid_seen = 0; done_seen = 0; valid1_seen = 0; done1_seen = 0;
      rd_num0 = 0; rd_num1 = 0; to_at = 0;
      if (!use_u1) begin
         for (int i = 0; i < n_exp; i++) begin
            a = b + 4'(i) * s;
            exp_addr_q.push_back(a);
            exp_rd_q.push_back({4'(i), mem[a]});
         end
      end
      @(negedge clk);
      base_addr = b; stride = s; count = c;
      if (use_u1) start1 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0; start1 = 1'b0;
      base_addr = 4'($urandom_range(0, 15));
      stride    = 4'($urandom_range(0, 15));
      count     = 4'($urandom_range(0, 15));
      lat = 1;
      while (!(use_u1 ? done1 : done0) && lat < 400) begin
         if (poke && lat == 2) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      if (lat >= 400) begin
         assert_cnt++;
         fail_cnt++;
         $display("FAIL seq_timeout: no done within %0d cycles, required done", lat);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      assert_cnt++;
      if ({busy0, done0, rd_valid0, err0, timeout0} !== 5'b0) begin
         fail_cnt++;
         $display("FAIL reset_flags: busy/done/valid/err/timeout=%b, required 00000",
                  {busy0, done0, rd_valid0, err0, timeout0});
      end
      assert_cnt++;
      if ({rd_data0, rd_index0, err_index0, err_resp0} !== 42'b0) begin
         fail_cnt++;
         $display("FAIL reset_data: data=%h idx=%h eidx=%h eresp=%b, required 0",
                  rd_data0, rd_index0, err_index0, err_resp0);
      end
      assert_cnt++;
      if ({ax0.m_arvalid, ax0.m_rready, ax0.m_araddr, ax0.m_arprot, dbg_state0} !== 11'b0) begin
         fail_cnt++;
         $display("FAIL reset_axi: arvalid=%b rready=%b araddr=%h arprot=%b state=%0d, required 0",
                  ax0.m_arvalid, ax0.m_rready, ax0.m_araddr, ax0.m_arprot, dbg_state0);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_common_end(input string name, input int lat, input int exp_lat,
                                  input int exp_valid);
      assert_cnt++;
      if (lat !== exp_lat) begin
         fail_cnt++;
         $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
      end
      assert_cnt++;
      if (valid_seen !== exp_valid || done_seen !== 1) begin
         fail_cnt++;
         $display("FAIL %s_pulses: valid=%0d done=%0d, required valid=%0d done=1",
                  name, valid_seen, done_seen, exp_valid);
      end
      assert_cnt++;
      if (exp_addr_q.size() != 0 || exp_rd_q.size() != 0) begin
         fail_cnt++;
         $display("FAIL %s_leftover: addr_q=%0d rd_q=%0d, required 0 0",
                  name, exp_addr_q.size(), exp_rd_q.size());
      end
   endtask

   task automatic test_single();
      int lat;
      run_seq(4'hC, 4'h0, 4'd1, 1, 1'b0, 1'b0, lat);
      test_common_end("single", lat, 3, 1);
      assert_cnt++;
      if (err0 !== 1'b0 || timeout0 !== 1'b0) begin
         fail_cnt++;
         $display("FAIL single_status: err=%b timeout=%b, required 0 0", err0, timeout0);
      end
   endtask

   task automatic test_seq4_with_busy_start();
      int lat;
      run_seq(4'h0, 4'h4, 4'd4, 4, 1'b0, 1'b1, lat);
      test_common_end("seq4", lat, 9, 4);
      assert_cnt++;
      if (ar_seen !== 4) begin
         fail_cnt++;
         $display("FAIL seq4_ar_count: got %0d, required 4", ar_seen);
      end
   endtask

   task automatic test_wrap();
      int lat;
      run_seq(4'hC, 4'h4, 4'd2, 2, 1'b0, 1'b1, lat);
      test_common_end("wrap", lat, 5, 2);
      assert_cnt++;
      if (err0 !== 1'b0) begin
         fail_cnt++;
         $display("FAIL wrap_err: got %b, required 0", err0);
      end
   endtask

   task automatic test_timeout();
      int lat;
      ar_delay = 20;
      run_seq(4'h3, 4'h5, 4'd1, 1, 1'b0, 1'b0, lat);
      ar_delay = 0;
      test_common_end("timeout", lat, 23, 1);
      assert_cnt++;
      if (timeout0 !== 1'b1) begin
         fail_cnt++;
         $display("FAIL timeout_flag: got %b, required 1", timeout0);
      end
      assert_cnt++;
      if (to_at < 16 || to_at > 18) begin
         fail_cnt++;
         $display("FAIL timeout_cycle: rose at ADDR cycle %0d, required 16..18", to_at);
      end
   endtask

   task automatic test_err_stop();
      int lat;
      err_num = 1;
      run_seq(4'h0, 4'h1, 4'd3, 2, 1'b0, 1'b0, lat);
      test_common_end("err_stop", lat, 5, 2);
      assert_cnt++;
      if ({err0, err_index0, err_resp0} !== {1'b1, 4'd1, 2'b10} || timeout0 !== 1'b0) begin
         fail_cnt++;
         $display("FAIL err_stop_status: err=%b idx=%0d resp=%b timeout=%b, required 1 1 10 0",
                  err0, err_index0, err_resp0, timeout0);
      end
      assert_cnt++;
      if (ar_seen !== 2) begin
         fail_cnt++;
         $display("FAIL err_stop_ar_count: got %0d, required 2", ar_seen);
      end
   endtask

   task automatic test_err_continue();
      int lat;
      err_num = 1;
      run_seq(4'h0, 4'h1, 4'd3, 0, 1'b1, 1'b0, lat);
      err_num = -1;
      assert_cnt++;
      if (valid1_seen !== 3 || done1_seen !== 1 || lat !== 7) begin
         fail_cnt++;
         $display("FAIL err_cont_pulses: valid=%0d done=%0d lat=%0d, required 3 1 7",
                  valid1_seen, done1_seen, lat);
      end
      assert_cnt++;
      if ({err1, err_index1, err_resp1} !== {1'b1, 4'd1, 2'b10}) begin
         fail_cnt++;
         $display("FAIL err_cont_status: err=%b idx=%0d resp=%b, required 1 1 10",
                  err1, err_index1, err_resp1);
      end
   endtask

   task automatic test_count_zero();
      int lat;
      run_seq(4'h7, 4'h1, 4'd0, 0, 1'b0, 1'b0, lat);
      test_common_end("count0", lat, 1, 0);
      assert_cnt++;
      if (ar_seen !== 0 || err0 !== 1'b0) begin
         fail_cnt++;
         $display("FAIL count0_status: ar=%0d err=%b, required 0 0", ar_seen, err0);
      end
   endtask

   task automatic test_reset_mid_data();
      int lat;
      int w;
      r_hold = 1'b1;
      done_seen = 0; valid_seen = 0;
      exp_addr_q.push_back(4'h5);
      @(negedge clk);
      base_addr = 4'h5; stride = 4'h1; count = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!ax0.m_rready && w < 50) begin
         @(negedge clk);
         w++;
      end
      assert_cnt++;
      if (ax0.m_rready !== 1'b1) begin
         fail_cnt++;
         $display("FAIL rst_mid_reach_data: rready=%b, required 1", ax0.m_rready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      assert_cnt++;
      if ({busy0, done0, rd_valid0, ax0.m_arvalid, ax0.m_rready, ax0.m_araddr, dbg_state0,
           rd_data0, rd_index0} !== 47'b0) begin
         fail_cnt++;
         $display("FAIL rst_mid_outputs: busy=%b done=%b arv=%b rrdy=%b araddr=%h state=%0d, required 0",
                  busy0, done0, ax0.m_arvalid, ax0.m_rready, ax0.m_araddr, dbg_state0);
      end
      rst = 1'b0;
      r_hold = 1'b0;
      repeat (3) @(negedge clk);
      assert_cnt++;
      if (done_seen !== 0 || valid_seen !== 0) begin
         fail_cnt++;
         $display("FAIL rst_mid_no_done: done=%0d valid=%0d, required 0 0", done_seen, valid_seen);
      end
      exp_addr_q.delete();
      exp_rd_q.delete();
      run_seq(4'h2, 4'h3, 4'd3, 3, 1'b0, 1'b0, lat);
      test_common_end("after_rst", lat, 7, 3);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      test_reset();
      test_single();
      test_seq4_with_busy_start();
      test_wrap();
      test_timeout();
      test_err_stop();
      test_err_continue();
      test_count_zero();
      test_reset_mid_data();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
